// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit scheduler.
package uart_pkg;

    localparam logic [1:0] BAUD_0 = 2'b00;
    localparam logic [1:0] BAUD_1 = 2'b01;
    localparam logic [1:0] BAUD_2 = 2'b10;
    localparam logic [1:0] BAUD_3 = 2'b11;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after `last`,
// wrapping around, so the previous winner has lowest priority.
import uart_pkg::*;

module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   last,
    output logic [IDW-1:0]   grant,
    output logic             any
);

    int unsigned idx;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (32'(last) + k) % N_REQ;
            if (!any && req[idx[IDW-1:0]]) begin
                any   = 1'b1;
                grant = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among N_REQ byte requesters: round-robin grant,
// one-cycle launch, wait for done_tx (with timeout), then an inter-frame gap.
import uart_pkg::*;

module uart_tx_sched #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned IDW        = $clog2(N_REQ),
    parameter int unsigned TIMEOUT    = 200000,
    parameter int unsigned TW         = 18,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [1:0]           cfg_baud,
    input  logic                 cfg_parity,
    output logic                 en,
    output logic [7:0]           data_in,
    output logic [1:0]           baud_rate,
    output logic                 parity_type,
    input  logic                 busy_tx,
    input  logic                 done_tx,
    output logic [IDW-1:0]       owner,
    output logic                 active,
    output logic                 timeout_err,
    output logic [15:0]          frame_cnt
);

    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    sched_state_t     state, state_d;
    logic [IDW-1:0]   last_grant, last_grant_d;
    logic [TW-1:0]    timer, timer_d;
    logic [GW-1:0]    gap_cnt, gap_cnt_d;
    logic             en_d, active_d, parity_d;
    logic [N_REQ-1:0] req_ready_d;
    logic [7:0]       data_in_d;
    logic [IDW-1:0]   owner_d;
    logic [15:0]      frame_cnt_d;
    logic [1:0]       baud_d;
    logic [IDW-1:0]   arb_grant;
    logic             arb_any;

    // busy_tx is status only; sequencing relies on done_tx alone.
    logic unused_busy;
    assign unused_busy = busy_tx;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .req   (req_valid),
        .last  (last_grant),
        .grant (arb_grant),
        .any   (arb_any)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            last_grant  <= IDW'(N_REQ - 1);
            timer       <= '0;
            gap_cnt     <= '0;
            en          <= 1'b0;
            req_ready   <= '0;
            data_in     <= '0;
            owner       <= '0;
            active      <= 1'b0;
            frame_cnt   <= '0;
            baud_rate   <= '0;
            parity_type <= 1'b0;
        end else begin
            state       <= state_d;
            last_grant  <= last_grant_d;
            timer       <= timer_d;
            gap_cnt     <= gap_cnt_d;
            en          <= en_d;
            req_ready   <= req_ready_d;
            data_in     <= data_in_d;
            owner       <= owner_d;
            active      <= active_d;
            frame_cnt   <= frame_cnt_d;
            baud_rate   <= baud_d;
            parity_type <= parity_d;
        end
    end

    // Next-state logic; timeout_err is decoded in the cycle the abort is decided.
    always_comb begin
        state_d      = state;
        last_grant_d = last_grant;
        timer_d      = timer;
        gap_cnt_d    = gap_cnt;
        en_d         = 1'b0;
        req_ready_d  = '0;
        data_in_d    = data_in;
        owner_d      = owner;
        active_d     = active;
        frame_cnt_d  = frame_cnt;
        baud_d       = baud_rate;
        parity_d     = parity_type;
        timeout_err  = 1'b0;

        case (state)
            IDLE: begin
                baud_d   = cfg_baud;
                parity_d = cfg_parity;
                if (arb_any) begin
                    data_in_d    = req_data[{arb_grant, 3'b000} +: 8];
                    owner_d      = arb_grant;
                    last_grant_d = arb_grant;
                    active_d     = 1'b1;
                    en_d         = 1'b1;
                    req_ready_d  = N_REQ'(1) << arb_grant;
                    state_d      = LAUNCH;
                end
            end
            LAUNCH: begin
                timer_d = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done_tx) begin
                    frame_cnt_d = frame_cnt + 16'd1;
                    gap_cnt_d   = '0;
                    state_d     = GAP;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    timeout_err = 1'b1;
                    gap_cnt_d   = '0;
                    state_d     = GAP;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    active_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized scoreboard bench for uart_tx_sched: a round-robin order model
// queues expected frames; a monitor checks each launch and its frame timing.
module tb_uart_tx_sched;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TO  = 300;
    localparam int TW  = 18;
    localparam int GAP = 2;

    typedef struct {
        int owner;
        int data;
        int delay;
    } exp_t;

    logic           clk = 1'b0;
    logic           rstn;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [1:0]     cfg_baud;
    logic           cfg_parity;
    logic           en;
    logic [7:0]     data_in;
    logic [1:0]     baud_rate;
    logic           parity_type;
    logic           busy_tx;
    logic           done_tx;
    logic           done_r;
    logic           done_s;
    logic [IDW-1:0] owner;
    logic           active;
    logic           timeout_err;
    logic [15:0]    frame_cnt;

    exp_t       exp_q[$];
    int         resp_q[$];
    int         plan_q[$];
    logic [7:0] bplan[$];
    logic [7:0] drv_q[N][$];
    logic [7:0] mq[N][$];
    int         model_last = N - 1;
    int         model_frames = 0;
    int         total = 0;
    int         bad = 0;

    assign done_tx = done_r | done_s;
    assign busy_tx = 1'b0;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .N_REQ      (N),
        .IDW        (IDW),
        .TIMEOUT    (TO),
        .TW         (TW),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .cfg_baud    (cfg_baud),
        .cfg_parity  (cfg_parity),
        .en          (en),
        .data_in     (data_in),
        .baud_rate   (baud_rate),
        .parity_type (parity_type),
        .busy_tx     (busy_tx),
        .done_tx     (done_tx),
        .owner       (owner),
        .active      (active),
        .timeout_err (timeout_err),
        .frame_cnt   (frame_cnt)
    );

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, act, expv, $time);
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++)
            if (drv_q[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    // Queue bytes per requester and derive the expected grant order from the
    // round-robin rule applied to the pending counts.
    task automatic load(input int cnt[N], input int dsel);
        int g;
        int d;
        int dat;
        logic [7:0] b;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < cnt[i]; k++) begin
                b = (bplan.size() > 0) ? bplan.pop_front() : 8'($urandom);
                drv_q[i].push_back(b);
                mq[i].push_back(b);
            end
        end
        for (int f = 0; f < 64; f++) begin
            g = -1;
            for (int k = 1; k <= N; k++)
                if (g < 0 && mq[(model_last + k) % N].size() > 0) g = (model_last + k) % N;
            if (g < 0) break;
            if (plan_q.size() > 0) d = plan_q.pop_front();
            else if (dsel >= 0) d = dsel;
            else begin
                case ($urandom_range(0, 9))
                    0:       d = 0;
                    1:       d = TO;
                    default: d = int'($urandom_range(1, 40));
                endcase
            end
            dat = int'(mq[g].pop_front());
            exp_q.push_back('{g, dat, d});
            resp_q.push_back(d);
            model_last = g;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (!(exp_q.size() == 0 && !active && all_empty()) && n < 10000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_bound", (n < 10000) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_en();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!en && n < 200);
        chk("wait_en_bound", int'(en), 1);
    endtask

    // Requesters: hold valid/data until req_ready, then present the next byte.
    initial begin : driver
        req_valid = '0;
        req_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (req_ready[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
                req_valid[i] = (drv_q[i].size() > 0);
                req_data[8*i +: 8] = (drv_q[i].size() > 0) ? drv_q[i][0] : 8'h00;
            end
        end
    end

    // Transmitter stand-in: done_tx d cycles after en, or never when d==0.
    initial begin : responder
        int d;
        done_r = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn && en) begin
                d = (resp_q.size() > 0) ? resp_q.pop_front() : 0;
                if (d > 0) begin
                    repeat (d) @(posedge clk);
                    #1 done_r = 1'b1;
                    @(posedge clk);
                    #1 done_r = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        exp_t cur;
        int   end_n;
        forever begin
            @(negedge clk);
            if (rstn && en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_en", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("owner", int'(owner), cur.owner);
                    chk("data_in", int'(data_in), cur.data);
                    chk("req_ready", int'(req_ready), 1 << cur.owner);
                    chk("active_launch", int'(active), 1);
                    end_n = (cur.delay > 0) ? cur.delay : TO;
                    for (int n = 1; n <= end_n + GAP + 1; n++) begin
                        @(negedge clk);
                        if (!rstn) break;
                        if (n == 1) begin
                            chk("en_width", int'(en), 0);
                            chk("ready_width", int'(req_ready), 0);
                        end
                        if (n == end_n) chk("timeout_err", int'(timeout_err), (cur.delay == 0) ? 1 : 0);
                        else if (timeout_err) chk("stray_timeout", 1, 0);
                        if (n == end_n + 1) begin
                            if (cur.delay > 0) model_frames = (model_frames + 1) & 16'hFFFF;
                            chk("frame_cnt", int'(frame_cnt), model_frames);
                            chk("data_hold", int'(data_in), cur.data);
                        end
                        if (n == end_n + GAP) chk("active_gap", int'(active), 1);
                        if (n == end_n + GAP + 1) chk("active_end", int'(active), 0);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cnt[N];
        int n;
        rstn       = 1'b0;
        cfg_baud   = 2'b11;
        cfg_parity = 1'b1;
        done_s     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_en", int'(en), 0);
        chk("rst_data_in", int'(data_in), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_owner", int'(owner), 0);
        chk("rst_active", int'(active), 0);
        chk("rst_timeout_err", int'(timeout_err), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        chk("rst_baud", int'(baud_rate), 0);
        chk("rst_parity", int'(parity_type), 0);
        cfg_baud   = 2'b00;
        cfg_parity = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Single requester 0 with 0xA5, done after 100 cycles.
        bplan.push_back(8'hA5);
        cnt = '{1, 0, 0, 0};
        load(cnt, 100);
        drain();

        // All requesting: strict rotation.
        cnt = '{2, 2, 2, 2};
        load(cnt, 50);
        drain();

        // Config change during WAIT_DONE is deferred to IDLE.
        cfg_baud = 2'b01;
        repeat (2) @(negedge clk);
        chk("cfg_idle_baud", int'(baud_rate), 1);
        cnt = '{0, 1, 0, 0};
        load(cnt, 60);
        wait_en();
        repeat (10) @(negedge clk);
        cfg_baud   = 2'b10;
        cfg_parity = 1'b1;
        @(negedge clk);
        chk("cfg_deferred_baud", int'(baud_rate), 1);
        chk("cfg_deferred_par", int'(parity_type), 0);
        n = 0;
        while (active && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("cfg_idle_entry_baud", int'(baud_rate), 1);
        @(negedge clk);
        chk("cfg_applied_baud", int'(baud_rate), 2);
        chk("cfg_applied_par", int'(parity_type), 1);
        drain();

        // Timeout on one frame, next requester still served.
        plan_q.push_back(0);
        plan_q.push_back(20);
        cnt = '{0, 1, 1, 0};
        load(cnt, 20);
        drain();

        // done_tx on the exact timeout cycle wins.
        cnt = '{0, 0, 0, 1};
        load(cnt, TO);
        drain();

        // done_tx while idle is ignored.
        @(posedge clk);
        #1 done_s = 1'b1;
        @(posedge clk);
        #1 done_s = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_done_ignored", int'(frame_cnt), model_frames);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) cnt[i] = int'($urandom_range(0, 3));
            load(cnt, -1);
            drain();
        end

        // Reset in WAIT_DONE abandons the frame; requester 0 wins afterwards.
        cnt = '{0, 0, 0, 1};
        load(cnt, 0);
        wait_en();
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midrst_en", int'(en), 0);
        chk("midrst_active", int'(active), 0);
        chk("midrst_owner", int'(owner), 0);
        chk("midrst_frame_cnt", int'(frame_cnt), 0);
        chk("midrst_timeout_err", int'(timeout_err), 0);
        model_frames = 0;
        model_last   = N - 1;
        exp_q.delete();
        resp_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        cnt = '{1, 0, 1, 0};
        load(cnt, 10);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
